// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: decoded packet, entry record,
// FU class codes and the CDB tag-match helper.
package reservation_station_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int AGE_W       = 4;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_ACU = 2'd1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
  } id_ex_packet_t;

  typedef struct packed {
    logic                   valid;
    id_ex_packet_t          pkt;
    logic [ROB_TAG_LEN-1:0] rs1_tag;
    logic [ROB_TAG_LEN-1:0] rs2_tag;
    logic [ROB_TAG_LEN-1:0] dest_tag;
    logic [AGE_W-1:0]       age;
  } rs_entry_t;

  // Tag 0 means "already resolved", so it must never match a broadcast.
  function automatic logic tag_hit(input logic                   cdb_valid,
                                   input logic [ROB_TAG_LEN-1:0] cdb_tag,
                                   input logic [ROB_TAG_LEN-1:0] tag);
    return cdb_valid && (tag != '0) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Oldest-ready picker: one-hot grant to the ready entry with the largest age.
module reservation_station_select
  import reservation_station_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            ready,
  input  logic [N-1:0][AGE_W-1:0] ages,
  output logic [N-1:0]            grant,
  output logic                    valid
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    grant    = '0;
    valid    = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!valid || ages[i] > best_age)) begin
        valid    = 1'b1;
        best_age = ages[i];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Per-FU reservation station: buffers dispatched instructions, wakes operands
// from the CDB and hands the oldest ready entry to the functional unit.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int         RS_SIZE = 4,
  parameter logic [1:0] FU_ID   = FU_ALU
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dispatch_en,
  input  logic [1:0]             dispatch_fu,
  input  id_ex_packet_t          dispatch_pkt,
  input  logic [ROB_TAG_LEN-1:0] rs1_tag,
  input  logic [ROB_TAG_LEN-1:0] rs2_tag,
  input  logic [ROB_TAG_LEN-1:0] dest_tag,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  input  logic                   flush,
  input  logic                   fu_ready,
  output logic                   rs_full,
  output logic                   issue_valid,
  output id_ex_packet_t          issue_pkt,
  output logic [ROB_TAG_LEN-1:0] issue_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RS_SIZE - 1);

  // Issue handshake: the entry presented on issue_* is consumed at a rising
  // edge where issue_valid && fu_ready; while fu_ready is low issue_* hold.

  rs_entry_t entries      [RS_SIZE];
  rs_entry_t entries_next [RS_SIZE];

  logic [RS_SIZE-1:0]            valid_vec;
  logic [RS_SIZE-1:0]            ready_vec;
  logic [RS_SIZE-1:0][AGE_W-1:0] age_vec;
  logic [RS_SIZE-1:0]            grant;
  logic                          sel_valid;
  logic [AGE_W-1:0]              sel_age;
  logic [IDX_W-1:0]              free_idx;
  logic                          accept;
  logic                          fire;
  rs_entry_t                     new_entry;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entries[i].valid;
      ready_vec[i] = entries[i].valid && (entries[i].rs1_tag == '0) &&
                     (entries[i].rs2_tag == '0);
      age_vec[i]   = entries[i].age;
    end
  end

  assign rs_full = &valid_vec;
  assign accept  = dispatch_en && (dispatch_fu == FU_ID) && !rs_full && !flush;

  reservation_station_select #(.N(RS_SIZE)) u_select (
    .ready (ready_vec),
    .ages  (age_vec),
    .grant (grant),
    .valid (sel_valid)
  );

  always_comb begin
    issue_pkt = '0;
    issue_tag = '0;
    sel_age   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        issue_pkt = entries[i].pkt;
        issue_tag = entries[i].dest_tag;
        sel_age   = entries[i].age;
      end
    end
  end

  assign issue_valid = sel_valid;
  assign fire        = sel_valid && fu_ready;

  // Lowest-index free slot, judged on current valid bits so a slot freed
  // by this cycle's issue is not reused until the next cycle.
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.pkt      = dispatch_pkt;
    new_entry.rs1_tag  = rs1_tag;
    new_entry.rs2_tag  = rs2_tag;
    new_entry.dest_tag = dest_tag;
    if (tag_hit(cdb_valid, cdb_tag, rs1_tag)) begin
      new_entry.pkt.rs1_value = cdb_value;
      new_entry.rs1_tag       = '0;
    end
    if (tag_hit(cdb_valid, cdb_tag, rs2_tag)) begin
      new_entry.pkt.rs2_value = cdb_value;
      new_entry.rs2_tag       = '0;
    end
  end

  // Ages are kept as ranks among live entries: entries older than a departing
  // one step down, so the saturating increment on dispatch never creates ties.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_next[i] = entries[i];
      if (entries[i].valid) begin
        if (fire && grant[i]) begin
          entries_next[i].valid = 1'b0;
        end else begin
          if (fire && entries[i].age > sel_age)
            entries_next[i].age = entries_next[i].age - 1'b1;
          if (accept && entries_next[i].age < AGE_MAX)
            entries_next[i].age = entries_next[i].age + 1'b1;
          if (tag_hit(cdb_valid, cdb_tag, entries[i].rs1_tag)) begin
            entries_next[i].pkt.rs1_value = cdb_value;
            entries_next[i].rs1_tag       = '0;
          end
          if (tag_hit(cdb_valid, cdb_tag, entries[i].rs2_tag)) begin
            entries_next[i].pkt.rs2_value = cdb_value;
            entries_next[i].rs2_tag       = '0;
          end
        end
      end
      if (accept && (free_idx == IDX_W'(i)))
        entries_next[i] = new_entry;
      if (flush)
        entries_next[i] = '0;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!reset) entries[i] <= '0;
      else        entries[i] <= entries_next[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, ready issue, CDB wake/bypass,
// backpressure, age order, flush and mid-wait reset.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                   clock;
  logic                   reset;
  logic                   dispatch_en;
  logic [1:0]             dispatch_fu;
  id_ex_packet_t          dispatch_pkt;
  logic [ROB_TAG_LEN-1:0] rs1_tag;
  logic [ROB_TAG_LEN-1:0] rs2_tag;
  logic [ROB_TAG_LEN-1:0] dest_tag;
  logic                   cdb_valid;
  logic [ROB_TAG_LEN-1:0] cdb_tag;
  logic [XLEN-1:0]        cdb_value;
  logic                   flush;
  logic                   fu_ready;
  logic                   rs_full;
  logic                   issue_valid;
  id_ex_packet_t          issue_pkt;
  logic [ROB_TAG_LEN-1:0] issue_tag;

  int checks = 0;
  int errors = 0;

  reservation_station #(.RS_SIZE(4), .FU_ID(FU_ALU)) dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_en  (dispatch_en),
    .dispatch_fu  (dispatch_fu),
    .dispatch_pkt (dispatch_pkt),
    .rs1_tag      (rs1_tag),
    .rs2_tag      (rs2_tag),
    .dest_tag     (dest_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .flush        (flush),
    .fu_ready     (fu_ready),
    .rs_full      (rs_full),
    .issue_valid  (issue_valid),
    .issue_pkt    (issue_pkt),
    .issue_tag    (issue_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_en  = 1'b0;
    dispatch_fu  = FU_ALU;
    dispatch_pkt = '0;
    rs1_tag      = '0;
    rs2_tag      = '0;
    dest_tag     = '0;
    cdb_valid    = 1'b0;
    cdb_tag      = '0;
    cdb_value    = '0;
    flush        = 1'b0;
  endtask

  task automatic set_dispatch(input logic [4:0] dest, input logic [4:0] t1, input logic [4:0] t2,
                              input logic [31:0] v1, input logic [31:0] v2);
    dispatch_en            = 1'b1;
    dispatch_fu            = FU_ALU;
    dispatch_pkt           = '0;
    dispatch_pkt.opcode    = OP_ADD;
    dispatch_pkt.dest_reg  = dest;
    dispatch_pkt.rs1_value = v1;
    dispatch_pkt.rs2_value = v2;
    rs1_tag                = t1;
    rs2_tag                = t2;
    dest_tag               = dest;
  endtask

  task automatic set_cdb(input logic [4:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = value;
  endtask

  initial begin
    idle();
    fu_ready = 1'b0;

    // 1. reset held with dispatch_en high
    reset = 1'b0;
    set_dispatch(5'd1, 5'd0, 5'd0, 32'h1, 32'h2);
    tick();
    tick();
    check("rst_full", rs_full, 1'b0);
    check("rst_valid", issue_valid, 1'b0);
    check("rst_tag", issue_tag, 5'd0);
    check("rst_pkt", issue_pkt, '0);
    idle();
    reset = 1'b1;
    tick();
    check("rst_no_write", issue_valid, 1'b0);

    // 2. ready dispatch, single-cycle handshake
    fu_ready = 1'b1;
    set_dispatch(5'd3, 5'd0, 5'd0, 32'd5, 32'd7);
    tick();
    idle();
    check("add_valid", issue_valid, 1'b1);
    check("add_tag", issue_tag, 5'd3);
    check("add_rs1", issue_pkt.rs1_value, 32'd5);
    check("add_rs2", issue_pkt.rs2_value, 32'd7);
    tick();
    check("add_freed", issue_valid, 1'b0);

    // 3. CDB wake of a stored entry
    set_dispatch(5'd4, 5'd2, 5'd0, 32'h0, 32'h22);
    tick();
    idle();
    check("wake_wait", issue_valid, 1'b0);
    set_cdb(5'd2, 32'h99);
    tick();
    idle();
    check("wake_valid", issue_valid, 1'b1);
    check("wake_tag", issue_tag, 5'd4);
    check("wake_rs1", issue_pkt.rs1_value, 32'h99);
    check("wake_rs2", issue_pkt.rs2_value, 32'h22);
    tick();
    check("wake_freed", issue_valid, 1'b0);

    // 3b. same-cycle bypass at dispatch
    fu_ready = 1'b0;
    set_dispatch(5'd7, 5'd0, 5'd6, 32'd3, 32'hdead);
    set_cdb(5'd6, 32'h11);
    tick();
    idle();
    check("byp_valid", issue_valid, 1'b1);
    check("byp_tag", issue_tag, 5'd7);
    check("byp_rs1", issue_pkt.rs1_value, 32'd3);
    check("byp_rs2", issue_pkt.rs2_value, 32'h11);
    fu_ready = 1'b1;
    tick();
    check("byp_freed", issue_valid, 1'b0);

    // 4. fill, drop while full, release one slot
    fu_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_dispatch(5'(i), 5'd0, 5'd0, 32'(i), 32'(i * 16));
      tick();
    end
    check("full_set", rs_full, 1'b1);
    check("full_oldest", issue_tag, 5'd1);
    set_dispatch(5'd8, 5'd0, 5'd0, 32'h8, 32'h8);
    tick();
    check("full_drop_full", rs_full, 1'b1);
    check("full_stable_tag", issue_tag, 5'd1);
    check("full_stable_rs1", issue_pkt.rs1_value, 32'd1);
    // leaving entry must not unblock a same-cycle dispatch
    set_dispatch(5'd9, 5'd0, 5'd0, 32'h9, 32'h9);
    fu_ready = 1'b1;
    tick();
    idle();
    fu_ready = 1'b0;
    check("full_release", rs_full, 1'b0);
    check("full_next_tag", issue_tag, 5'd2);
    fu_ready = 1'b1;
    tick();
    check("drain_tag3", issue_tag, 5'd3);
    tick();
    check("drain_tag4", issue_tag, 5'd4);
    tick();
    check("drain_empty", issue_valid, 1'b0);

    // 5. age order
    fu_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_dispatch(5'(i), 5'd0, 5'd0, 32'(i), 32'(i));
      tick();
    end
    idle();
    fu_ready = 1'b1;
    check("age_first", issue_tag, 5'd1);
    tick();
    check("age_second", issue_tag, 5'd2);
    tick();
    check("age_third", issue_tag, 5'd3);
    tick();
    check("age_empty", issue_valid, 1'b0);

    // 5b. younger ready entry overtakes an older waiting one
    fu_ready = 1'b0;
    set_dispatch(5'd5, 5'd9, 5'd0, 32'h0, 32'h1);
    tick();
    set_dispatch(5'd6, 5'd0, 5'd0, 32'h6, 32'h6);
    tick();
    idle();
    check("ooo_young", issue_tag, 5'd6);
    fu_ready = 1'b1;
    tick();
    check("ooo_waiting", issue_valid, 1'b0);
    set_cdb(5'd9, 32'h55);
    tick();
    idle();
    check("ooo_old_tag", issue_tag, 5'd5);
    check("ooo_old_rs1", issue_pkt.rs1_value, 32'h55);
    tick();
    check("ooo_empty", issue_valid, 1'b0);

    // 6. flush beats dispatch
    fu_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_dispatch(5'(i), 5'd0, 5'd0, 32'(i), 32'(i));
      tick();
    end
    check("fl_pre_valid", issue_valid, 1'b1);
    set_dispatch(5'd10, 5'd0, 5'd0, 32'ha, 32'ha);
    flush = 1'b1;
    tick();
    idle();
    check("fl_valid", issue_valid, 1'b0);
    check("fl_full", rs_full, 1'b0);

    // dispatch aimed at the other FU class is ignored
    set_dispatch(5'd11, 5'd0, 5'd0, 32'hb, 32'hb);
    dispatch_fu = FU_ACU;
    tick();
    idle();
    check("fu_mismatch", issue_valid, 1'b0);

    // 6b. reset mid-wait drops the entry
    set_dispatch(5'd4, 5'd7, 5'd0, 32'h0, 32'h0);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_cdb(5'd7, 32'h77);
    tick();
    idle();
    check("rst_mid_drop", issue_valid, 1'b0);
    check("rst_mid_full", rs_full, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
